// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the architectural PC, steers the shared external PC adder between
// sequential increment and PC-relative redirect, and offers the PC to fetch over valid/ready.
// Optional zero-overhead loop support is compiled in when PC_SEQ_LOOP_EN is defined;
// without it the loop_* inputs are ignored and loop_active_o is tied low.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] INSTR_BYTES = 32'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        fetch_valid_o,
  input  logic        fetch_ready_i,
  output logic [31:0] fetch_pc_o,
  input  logic        br_valid_i,
  output logic        br_ready_o,
  input  logic [31:0] br_pc_i,
  input  logic [31:0] br_offset_i,
  input  logic        halt_req_i,
  output logic        halted_o,
  output logic        pc_misalign_o,
  input  logic        loop_cfg_valid_i,
  input  logic [31:0] loop_start_pc_i,
  input  logic [31:0] loop_end_pc_i,
  input  logic [15:0] loop_count_i,
  output logic        loop_active_o,
  output logic [31:0] add_a_o,
  output logic [31:0] add_b_o,
  input  logic [31:0] add_sum_i
);

  typedef enum logic [1:0] {StBoot, StRun, StHalt} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        misalign_q, misalign_d;
  logic        fetch_fire, br_fire, loop_back;

  // Handshake qualifiers and status outputs decoded from the current state.
  always_comb begin
    fetch_valid_o = (state_q == StRun) && !halt_req_i;
    br_ready_o    = (state_q != StBoot);
    halted_o      = (state_q == StHalt);
    fetch_fire    = fetch_valid_o && fetch_ready_i;
    br_fire       = br_valid_i && br_ready_o;
    fetch_pc_o    = pc_q;
    pc_misalign_o = misalign_q;
  end

  // Adder operand mux: an accepted redirect owns the adder, otherwise it increments the PC.
  always_comb begin
    if (br_fire) begin
      add_a_o = br_pc_i;
      add_b_o = br_offset_i;
    end else begin
      add_a_o = pc_q;
      add_b_o = INSTR_BYTES;
    end
  end

`ifdef PC_SEQ_LOOP_EN
  logic [31:0] loop_start_q, loop_start_d;
  logic [31:0] loop_end_q, loop_end_d;
  logic [15:0] remaining_q, remaining_d;
  logic        loop_hit;

  // Loop bookkeeping: a config write always wins; redirects leave the counter untouched.
  always_comb begin
    loop_start_d  = loop_start_q;
    loop_end_d    = loop_end_q;
    remaining_d   = remaining_q;
    loop_hit      = fetch_fire && !br_fire && (pc_q == loop_end_q) && (remaining_q != 16'd0);
    loop_back     = loop_hit && (remaining_q > 16'd1);
    loop_active_o = (remaining_q != 16'd0);
    if (loop_cfg_valid_i) begin
      loop_start_d = loop_start_pc_i;
      loop_end_d   = loop_end_pc_i;
      remaining_d  = loop_count_i;
    end else if (loop_hit) begin
      // Final iteration falls through and drops the counter to zero.
      remaining_d = remaining_q - 16'd1;
    end
  end

  // Loop registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loop_start_q <= 32'h0;
      loop_end_q   <= 32'h0;
      remaining_q  <= 16'd0;
    end else begin
      loop_start_q <= loop_start_d;
      loop_end_q   <= loop_end_d;
      remaining_q  <= remaining_d;
    end
  end
`else
  logic        unused_loop;
  logic [31:0] loop_start_q;

  // Loop path absent: inputs are folded away and the loop-back term is never taken.
  always_comb begin
    loop_back     = 1'b0;
    loop_active_o = 1'b0;
    loop_start_q  = 32'h0;
    unused_loop   = ^{loop_cfg_valid_i, loop_start_pc_i, loop_end_pc_i, loop_count_i};
  end
`endif

  // FSM and next-PC selection, redirect > loop-back > increment > hold.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    misalign_d = br_fire && (add_sum_i[1:0] != 2'b00);
    unique case (state_q)
      StBoot:  state_d = StRun;
      StRun:   if (halt_req_i) state_d = StHalt;
      StHalt:  if (!halt_req_i) state_d = StRun;
      default: state_d = StBoot;
    endcase
    if (br_fire) begin
      pc_d = {add_sum_i[31:2], 2'b00};
    end else if (loop_back) begin
      pc_d = loop_start_q;
    end else if (fetch_fire) begin
      pc_d = add_sum_i;
    end
  end

  // State, PC and misalign pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StBoot;
      pc_q       <= RESET_PC;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer; models the external PC adder.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_valid, fetch_ready;
  logic [31:0] fetch_pc;
  logic        br_valid, br_ready;
  logic [31:0] br_pc, br_offset;
  logic        halt_req, halted, pc_misalign;
  logic        loop_cfg_valid;
  logic [31:0] loop_start_pc, loop_end_pc;
  logic [15:0] loop_count;
  logic        loop_active;
  logic [31:0] add_a, add_b, add_sum;

  int checks = 0;
  int errors = 0;

  assign add_sum = add_a + add_b;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .fetch_valid_o    (fetch_valid),
    .fetch_ready_i    (fetch_ready),
    .fetch_pc_o       (fetch_pc),
    .br_valid_i       (br_valid),
    .br_ready_o       (br_ready),
    .br_pc_i          (br_pc),
    .br_offset_i      (br_offset),
    .halt_req_i       (halt_req),
    .halted_o         (halted),
    .pc_misalign_o    (pc_misalign),
    .loop_cfg_valid_i (loop_cfg_valid),
    .loop_start_pc_i  (loop_start_pc),
    .loop_end_pc_i    (loop_end_pc),
    .loop_count_i     (loop_count),
    .loop_active_o    (loop_active),
    .add_a_o          (add_a),
    .add_b_o          (add_b),
    .add_sum_i        (add_sum)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] exp_pc [10];
  logic        exp_act [10];

  initial begin
    rst_n = 1'b0; fetch_ready = 1'b1; br_valid = 1'b0; br_pc = '0; br_offset = '0;
    halt_req = 1'b0; loop_cfg_valid = 1'b0; loop_start_pc = '0; loop_end_pc = '0;
    loop_count = '0;
    tick(); tick();
    check("rst_pc", fetch_pc, 32'h0);
    check("rst_valid", {31'b0, fetch_valid}, 32'd0);
    check("rst_br_ready", {31'b0, br_ready}, 32'd0);
    check("rst_halted", {31'b0, halted}, 32'd0);
    check("rst_misalign", {31'b0, pc_misalign}, 32'd0);
    check("rst_loop_active", {31'b0, loop_active}, 32'd0);

    // Reset release: BOOT for one cycle, then sequential fetch.
    rst_n = 1'b1;
    #1 check("boot_valid", {31'b0, fetch_valid}, 32'd0);
    tick(); check("run_valid", {31'b0, fetch_valid}, 32'd1);
    check("seq_pc0", fetch_pc, 32'h0);
    check("br_ready_run", {31'b0, br_ready}, 32'd1);
    tick(); check("seq_pc4", fetch_pc, 32'h4);
    tick(); check("seq_pc8", fetch_pc, 32'h8);
    tick(); check("seq_pc12", fetch_pc, 32'hC);
    tick(); check("seq_pc16", fetch_pc, 32'h10);

    // Backpressure holds the PC.
    fetch_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); check("bp_hold", fetch_pc, 32'h10);
    end
    fetch_ready = 1'b1;
    tick(); check("bp_resume", fetch_pc, 32'h14);

    // Redirect concurrent with an accepted fetch.
    br_valid = 1'b1; br_pc = 32'h100; br_offset = 32'hFFFF_FFF8;
    #1 check("mux_a_br", add_a, 32'h100);
    check("mux_b_br", add_b, 32'hFFFF_FFF8);
    tick(); br_valid = 1'b0;
    #1 check("redir_pc", fetch_pc, 32'hF8);
    check("redir_no_misalign", {31'b0, pc_misalign}, 32'd0);
    check("mux_a_seq", add_a, 32'hF8);
    check("mux_b_seq", add_b, 32'h4);

    // Misaligned redirect: aligned target plus one-cycle pulse.
    br_valid = 1'b1; br_pc = 32'h200; br_offset = 32'h2;
    tick(); br_valid = 1'b0;
    #1 check("misalign_pc", fetch_pc, 32'h200);
    check("misalign_pulse", {31'b0, pc_misalign}, 32'd1);
    tick(); check("misalign_clear", {31'b0, pc_misalign}, 32'd0);
    check("after_misalign_pc", fetch_pc, 32'h204);

    // Halt at 0x40 with a redirect to 0x80 while halted.
    br_valid = 1'b1; br_pc = 32'h40; br_offset = 32'h0;
    tick(); br_valid = 1'b0; halt_req = 1'b1;
    #1 check("halt_pc", fetch_pc, 32'h40);
    check("halt_valid_drop", {31'b0, fetch_valid}, 32'd0);
    check("halt_not_yet", {31'b0, halted}, 32'd0);
    tick(); check("halted_set", {31'b0, halted}, 32'd1);
    check("halt_pc_hold", fetch_pc, 32'h40);
    br_valid = 1'b1; br_pc = 32'h80; br_offset = 32'h0;
    #1 check("halt_br_ready", {31'b0, br_ready}, 32'd1);
    tick(); br_valid = 1'b0;
    #1 check("halt_redir_pc", fetch_pc, 32'h80);
    check("halt_stays", {31'b0, halted}, 32'd1);
    tick(); tick(); tick();
    check("halt_valid_low", {31'b0, fetch_valid}, 32'd0);
    halt_req = 1'b0;
    #1 check("halt_release_same", {31'b0, halted}, 32'd1);
    tick(); check("halted_clear", {31'b0, halted}, 32'd0);
    check("resume_valid", {31'b0, fetch_valid}, 32'd1);
    check("resume_pc", fetch_pc, 32'h80);
    tick(); check("resume_pc_inc", fetch_pc, 32'h84);

    // Modulo 2^32 wrap.
    br_valid = 1'b1; br_pc = 32'hFFFF_FFFC; br_offset = 32'h0;
    tick(); br_valid = 1'b0;
    #1 check("wrap_top", fetch_pc, 32'hFFFF_FFFC);
    tick(); check("wrap_zero", fetch_pc, 32'h0);

    // Loop 0x20..0x28, count 3, configured alongside a redirect to 0x20.
    fetch_ready = 1'b0;
    br_valid = 1'b1; br_pc = 32'h20; br_offset = 32'h0;
    loop_cfg_valid = 1'b1; loop_start_pc = 32'h20; loop_end_pc = 32'h28; loop_count = 16'd3;
    tick(); br_valid = 1'b0; loop_cfg_valid = 1'b0;
`ifdef PC_SEQ_LOOP_EN
    exp_pc = '{32'h20, 32'h24, 32'h28, 32'h20, 32'h24, 32'h28, 32'h20, 32'h24, 32'h28, 32'h2C};
    exp_act = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
`else
    exp_pc = '{32'h20, 32'h24, 32'h28, 32'h2C, 32'h30, 32'h34, 32'h38, 32'h3C, 32'h40, 32'h44};
    exp_act = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
    fetch_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1 check("loop_pc", fetch_pc, exp_pc[i]);
      check("loop_active", {31'b0, loop_active}, {31'b0, exp_act[i]});
      tick();
    end

    // Asynchronous reset mid-cycle.
    #2 rst_n = 1'b0;
    #1 check("async_rst_pc", fetch_pc, 32'h0);
    check("async_rst_valid", {31'b0, fetch_valid}, 32'd0);
    check("async_rst_br_ready", {31'b0, br_ready}, 32'd0);
    tick(); rst_n = 1'b1;
    tick(); check("rerun_valid", {31'b0, fetch_valid}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer for the vector processing unit front end. Owns the architectural PC register and drives the shared 32-bit PC adder, which is instantiated alongside it and is purely combinational. Arbitrates the adder between sequential increment and PC-relative branch redirect. Presents the PC to instruction fetch over a valid/ready handshake, with halt support and optional zero-overhead loop support.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- INSTR_BYTES, 4, sequential increment added per accepted fetch
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- fetch_valid  out  1  fetch_pc is valid for fetch
- fetch_ready  in  1  fetch accepts fetch_pc this cycle
- fetch_pc  out  32  current PC
- br_valid  in  1  redirect request
- br_ready  out  1  redirect can be accepted
- br_pc  in  32  PC of the branch instruction
- br_offset  in  32  signed byte offset; target = br_pc + br_offset
- halt_req  in  1  level request to stop issuing fetches
- halted  out  1  sequencer is in HALT
- pc_misalign  out  1  one-cycle pulse: accepted target had bits[1:0] != 0
- loop_cfg_valid  in  1  load loop registers (loop feature only)
- loop_start_pc  in  32  loop body first PC
- loop_end_pc  in  32  loop body last PC
- loop_count  in  16  iteration count; 0 = no loop
- loop_active  out  1  loop counter armed
- add_a  out  32  PC adder operand A
- add_b  out  32  PC adder operand B
- add_sum  in  32  PC adder result (same cycle)

## Operation
- FSM states: BOOT, RUN, HALT.
- BOOT -> RUN unconditionally on the first clock after rst_n deasserts.
- RUN -> HALT when halt_req = 1.
- HALT -> RUN when halt_req = 0.
- fetch_valid = (state == RUN) and not halt_req. This is combinational.
- br_ready = (state != BOOT).
- halted = (state == HALT).
- Fetch handshake: fetch_pc is held stable while fetch_valid = 1 and fetch_ready = 0, unless a redirect is accepted.
- Adder mux:
  - If br_valid and br_ready: add_a = br_pc, add_b = br_offset.
  - Otherwise: add_a = fetch_pc, add_b = INSTR_BYTES.
- Next-PC priority, highest first:
  1. Accepted redirect: pc <= {add_sum[31:2], 2'b00}. pc_misalign pulses next cycle if add_sum[1:0] != 0.
  2. Loop-back, when accepted fetch_pc == loop_end_pc and remaining > 1: pc <= loop_start_pc, remaining decrements.
  3. Accepted fetch: pc <= add_sum.
  4. Otherwise: pc holds.
- A redirect in the same cycle as an accepted fetch retires that fetch and takes the target. The loop counter is unchanged by redirects.
- A redirect accepted in HALT updates the PC; the state stays HALT.
- Arithmetic is modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.
- Loop registers:
  - loop_cfg_valid loads start/end and sets remaining = loop_count. This overwrites any active loop.
  - loop_active = (remaining != 0).
  - On the accepted fetch of loop_end_pc with remaining == 1, the PC falls through (pc <= add_sum) and remaining becomes 0.

## Timing
- Reset values:
  - fetch_pc = RESET_PC, state = BOOT.
  - fetch_valid = 0, br_ready = 0, halted = 0, pc_misalign = 0.
  - loop_active = 0, remaining = 0.
- Reset mid-operation aborts immediately, asynchronously, to the values above.
- Redirect latency is 1 cycle: accepted in cycle N, the target appears on fetch_pc in cycle N+1.
- Increment latency is 1 cycle after the accepting handshake edge.
- halt_req drops fetch_valid in the same cycle. halted asserts the next cycle and deasserts the cycle after halt_req falls.
- The first fetch_valid = 1 occurs on the second cycle after reset release (BOOT lasts one cycle).

## Configuration
- PC_SEQ_LOOP_EN defined:
  - Loop registers, decrement and loop-back path are compiled in.
- PC_SEQ_LOOP_EN undefined:
  - loop_* ports remain present; the inputs are ignored.
  - loop_active is tied 0.
  - Priority 2 does not exist.

## Test plan
- Reset release, fetch_ready = 1 for 4 cycles -> fetch_pc sequence RESET_PC, +4, +8, +12; fetch_valid low during BOOT.
- Backpressure: fetch_ready = 0 for 3 cycles at pc 0x10 -> fetch_pc holds 0x10; advances to 0x14 one cycle after ready returns.
- Redirect with br_pc = 0x100, br_offset = -8, concurrent with an accepted fetch -> fetch_pc = 0xF8 next cycle, no +4 step.
- Misaligned redirect to target 0x202 -> fetch_pc = 0x200; pc_misalign is a single-cycle pulse.
- halt_req held 5 cycles at pc 0x40 -> fetch_valid = 0, halted = 1; redirect to 0x80 during halt; after release fetch resumes at 0x80.
- With PC_SEQ_LOOP_EN, loop 0x20..0x28 with count 3 -> body fetched 3 times, then 0x2C; loop_active falls when 0x2C is issued. Without the macro -> straight-line 0x20, 0x24, 0x28, 0x2C.
